// File: rtl/datapath_core_pkg.sv
// Shared constants, ALU op codes and instruction-field decode for datapath_core.
package datapath_core_pkg;
   localparam int XLEN = 64;

   typedef enum logic [1:0] {
      ALU_SUB = 2'b00,
      ALU_ADD = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   localparam int RD_LSB       = 7;
   localparam int RS1_LSB      = 15;
   localparam int RS2_LSB      = 20;
   localparam int IMM_I_LSB    = 20;
   localparam int IMM_S_HI_LSB = 25;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm_i;
      logic [11:0] imm_s;
   } instr_fields_t;

   // Immediates stay raw 12-bit here; the consumer sign-extends to its own width.
   function automatic instr_fields_t decode(input logic [31:0] instr);
      instr_fields_t f;
      f.rd    = instr[RD_LSB +: 5];
      f.rs1   = instr[RS1_LSB +: 5];
      f.rs2   = instr[RS2_LSB +: 5];
      f.imm_i = instr[IMM_I_LSB +: 12];
      f.imm_s = {instr[IMM_S_HI_LSB +: 7], instr[RD_LSB +: 5]};
      return f;
   endfunction
endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU: add, sub, and, or; overflow ignored.
module alu
   import datapath_core_pkg::ALU_SUB;
   import datapath_core_pkg::ALU_ADD;
   import datapath_core_pkg::ALU_AND;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [1:0]      op_i,
   output logic [XLEN-1:0] y_o
);
   always_comb begin
      y_o = a_i | b_i;
      case (op_i)
         ALU_ADD: y_o = a_i + b_i;
         ALU_SUB: y_o = a_i - b_i;
         ALU_AND: y_o = a_i & b_i;
         default: y_o = a_i | b_i;
      endcase
   end
endmodule

// File: rtl/data_ram.sv
// Data RAM: async read, sync write, reset seeds word i with value i.
module data_ram #(
   parameter int  XLEN  = 64,
   parameter int  WORDS = 32,
   localparam int AW    = $clog2(WORDS)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [AW-1:0]   addr_i,
   output logic [XLEN-1:0] rdata_o,
   input  logic            we_i,
   input  logic [XLEN-1:0] wdata_i
);
   logic [XLEN-1:0] mem_q [WORDS];

   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= XLEN'(i);
      end else if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end
endmodule

// File: rtl/imem.sv
// Instruction ROM; the image is an elaboration-time constant, read combinationally.
module imem #(
   parameter int                         WORDS = 32,
   parameter logic [WORDS-1:0][31:0]     DATA  = '0,
   localparam int                        AW    = $clog2(WORDS)
) (
   input  logic [AW-1:0] addr_i,
   output logic [31:0]   instr_o
);
   assign instr_o = DATA[addr_i];
endmodule

// File: rtl/mux2.sv
// Generic two-input mux.
module mux2 #(
   parameter int W = 64
) (
   input  logic         sel_i,
   input  logic [W-1:0] d0_i,
   input  logic [W-1:0] d1_i,
   output logic [W-1:0] y_o
);
   assign y_o = sel_i ? d1_i : d0_i;
endmodule

// File: rtl/pc_reg.sv
// Program counter: advances one 32-bit instruction per clock, wraps naturally.
module pc_reg #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   output logic [XLEN-1:0] pc_o
);
   logic [XLEN-1:0] pc_q, pc_d;

   assign pc_d = pc_q + XLEN'(4);
   assign pc_o = pc_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) pc_q <= '0;
      else         pc_q <= pc_d;
   end
endmodule

// File: rtl/regfile.sv
// Register file: two async read ports, one sync write port, x0 reads as zero.
module regfile #(
   parameter int  XLEN = 64,
   parameter int  NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [AW-1:0]   ra1_i,
   input  logic [AW-1:0]   ra2_i,
   output logic [XLEN-1:0] rd1_o,
   output logic [XLEN-1:0] rd2_o,
   input  logic            we_i,
   input  logic [AW-1:0]   wa_i,
   input  logic [XLEN-1:0] wd_i
);
   logic [XLEN-1:0] regs_q [NREG];

   assign rd1_o = regs_q[ra1_i];
   assign rd2_o = regs_q[ra2_i];

   // Reset seeds reg[i]=i, which also leaves x0 at its hardwired zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= XLEN'(i);
      end else if (we_i && (wa_i != '0)) begin
         regs_q[wa_i] <= wd_i;
      end
   end
endmodule

// File: rtl/datapath_core.sv
// Single-cycle load/store/ALU datapath; an external control unit drives the enables.
module datapath_core
   import datapath_core_pkg::instr_fields_t;
   import datapath_core_pkg::decode;
#(
   parameter int                          XLEN       = datapath_core_pkg::XLEN,
   parameter int                          NREG       = 32,
   parameter int                          RAM_WORDS  = 32,
   parameter int                          IMEM_WORDS = 32,
   parameter logic [IMEM_WORDS-1:0][31:0] IMEM_DATA  = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_en,
   input  logic            store_en,
   input  logic [1:0]      op_ula,
   input  logic            operation_type,
   input  logic            ula_entry,
   output logic [XLEN-1:0] program_counter
);
   localparam int IMEM_AW = $clog2(IMEM_WORDS);
   localparam int RAM_AW  = $clog2(RAM_WORDS);

   logic [31:0]     instr;
   instr_fields_t   f;
   logic [XLEN-1:0] rs1_val, rs2_val, imm_i_x, imm_s_x;
   logic [XLEN-1:0] hi_b, alu_b, alu_y, ram_rdata, wb_val;

   pc_reg #(.XLEN(XLEN)) u_pc (
      .clk_i (clk),
      .rst_ni(reset),
      .pc_o  (program_counter)
   );

   imem #(.WORDS(IMEM_WORDS), .DATA(IMEM_DATA)) u_imem (
      .addr_i (program_counter[IMEM_AW+1:2]),
      .instr_o(instr)
   );

   assign f       = decode(instr);
   assign imm_i_x = {{(XLEN-12){f.imm_i[11]}}, f.imm_i};
   assign imm_s_x = {{(XLEN-12){f.imm_s[11]}}, f.imm_s};

   regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk_i (clk),
      .rst_ni(reset),
      .ra1_i (f.rs1),
      .ra2_i (f.rs2),
      .rd1_o (rs1_val),
      .rd2_o (rs2_val),
      .we_i  (load_en),
      .wa_i  (f.rd),
      .wd_i  (wb_val)
   );

   // ula_entry=1 picks rs2 for arithmetic but the store offset for memory ops.
   mux2 #(.W(XLEN)) u_mux_hi (
      .sel_i(operation_type),
      .d0_i (imm_s_x),
      .d1_i (rs2_val),
      .y_o  (hi_b)
   );

   mux2 #(.W(XLEN)) u_mux_b (
      .sel_i(ula_entry),
      .d0_i (imm_i_x),
      .d1_i (hi_b),
      .y_o  (alu_b)
   );

   alu #(.XLEN(XLEN)) u_alu (
      .a_i (rs1_val),
      .b_i (alu_b),
      .op_i(op_ula),
      .y_o (alu_y)
   );

   data_ram #(.XLEN(XLEN), .WORDS(RAM_WORDS)) u_ram (
      .clk_i  (clk),
      .rst_ni (reset),
      .addr_i (alu_y[RAM_AW-1:0]),
      .rdata_o(ram_rdata),
      .we_i   (store_en),
      .wdata_i(rs2_val)
   );

   mux2 #(.W(XLEN)) u_mux_wb (
      .sel_i(operation_type),
      .d0_i (ram_rdata),
      .d1_i (alu_y),
      .y_o  (wb_val)
   );
endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench: directed program then random controls against a behavioural model.
module tb_datapath_core;
   logic        clk = 1'b0;
   logic        reset, load_en, store_en, operation_type, ula_entry;
   logic [1:0]  op_ula;
   logic [63:0] program_counter;

   function automatic logic [31:0] enc_i(input int rd, input int rs1, input int imm);
      logic [11:0] im;
      im = imm[11:0];
      return {im, 5'(rs1), 3'b000, 5'(rd), 7'b0000011};
   endfunction

   function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
      return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
      logic [11:0] im;
      im = imm[11:0];
      return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0][31:0] build_prog();
      logic [31:0][31:0] p;
      logic [31:0]       s;
      p    = '0;
      p[0] = enc_i(1, 0, 7);
      p[1] = enc_r(31, 7, 21);
      p[2] = enc_r(30, 17, 31);
      p[3] = enc_i(29, 5, 81);
      p[4] = enc_i(28, 3, 42);
      p[5] = enc_s(29, 28, 40);
      p[6] = enc_i(2, 3, 32);
      p[7] = enc_i(0, 5, 9);
      s    = 32'h1234_5678;
      for (int k = 8; k < 32; k++) begin
         s    = s * 32'd1664525 + 32'd1013904223;
         p[k] = s;
      end
      return p;
   endfunction

   localparam logic [31:0][31:0] PROG = build_prog();

   datapath_core #(.IMEM_DATA(PROG)) dut (
      .clk            (clk),
      .reset          (reset),
      .load_en        (load_en),
      .store_en       (store_en),
      .op_ula         (op_ula),
      .operation_type (operation_type),
      .ula_entry      (ula_entry),
      .program_counter(program_counter)
   );

   always #5 clk = ~clk;

   logic [63:0] m_reg [32];
   logic [63:0] m_ram [32];
   logic [63:0] m_pc;
   int          checks = 0;
   int          errors = 0;

   function automatic logic [63:0] sext12(input logic [11:0] v);
      return {{52{v[11]}}, v};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = 64'(i);
         m_ram[i] = 64'(i);
      end
      m_reg[0] = 64'd0;
      m_pc     = 64'd0;
   endtask

   // One architectural instruction: all reads see pre-edge state.
   task automatic model_step(input logic le, input logic se, input logic [1:0] op,
                             input logic ot, input logic ue);
      logic [31:0] ins;
      logic [63:0] a, b, y, st, rdat;
      int          rd, rs1, rs2, addr;
      ins  = PROG[m_pc[6:2]];
      rd   = int'(ins[11:7]);
      rs1  = int'(ins[19:15]);
      rs2  = int'(ins[24:20]);
      a    = m_reg[rs1];
      st   = m_reg[rs2];
      if (ue) b = ot ? st : sext12({ins[31:25], ins[11:7]});
      else    b = sext12(ins[31:20]);
      case (op)
         2'b01:   y = a + b;
         2'b00:   y = a - b;
         2'b10:   y = a & b;
         default: y = a | b;
      endcase
      addr = int'(y % 64'd32);
      rdat = m_ram[addr];
      if (se) m_ram[addr] = st;
      if (le && rd != 0) m_reg[rd] = ot ? y : rdat;
      m_pc = m_pc + 64'd4;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk($sformatf("%s pc", tag), program_counter, m_pc);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("%s x%0d", tag, i), dut.u_rf.regs_q[i], m_reg[i]);
         chk($sformatf("%s ram%0d", tag, i), dut.u_ram.mem_q[i], m_ram[i]);
      end
   endtask

   // Called at a negedge: drive controls, advance model, check after the edge.
   task automatic cycle(input logic le, input logic se, input logic [1:0] op,
                        input logic ot, input logic ue, input string tag);
      load_en        = le;
      store_en       = se;
      op_ula         = op;
      operation_type = ot;
      ula_entry      = ue;
      model_step(le, se, op, ot, ue);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic rand_cycles(input int n, input string tag);
      logic [31:0] r;
      for (int k = 0; k < n; k++) begin
         r = $urandom;
         cycle(r[0] | r[6], r[1], r[3:2], r[4], r[5], tag);
      end
   endtask

   initial begin
      reset = 1'b0; load_en = 1'b1; store_en = 1'b1;
      op_ula = 2'b01; operation_type = 1'b0; ula_entry = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      chk("reset x5 literal", dut.u_rf.regs_q[5], 64'd5);
      chk("reset ram9 literal", dut.u_ram.mem_q[9], 64'd9);
      reset = 1'b1;

      cycle(1, 0, 2'b01, 0, 0, "load x1");
      chk("lit pc after load", program_counter, 64'd4);
      cycle(1, 0, 2'b01, 1, 1, "add x31");
      cycle(1, 0, 2'b00, 1, 1, "sub x30");
      cycle(1, 0, 2'b01, 1, 0, "addi x29");
      cycle(1, 0, 2'b00, 1, 0, "subi x28");
      cycle(0, 1, 2'b01, 0, 1, "store");
      chk("lit x1", dut.u_rf.regs_q[1], 64'd7);
      chk("lit x31", dut.u_rf.regs_q[31], 64'd28);
      chk("lit x30", dut.u_rf.regs_q[30], 64'hFFFF_FFFF_FFFF_FFF5);
      chk("lit x29", dut.u_rf.regs_q[29], 64'd86);
      chk("lit x28", dut.u_rf.regs_q[28], 64'hFFFF_FFFF_FFFF_FFD9);
      chk("lit ram1", dut.u_ram.mem_q[1], 64'd86);
      chk("lit pc 24", program_counter, 64'd24);
      chk("model x30", m_reg[30], 64'hFFFF_FFFF_FFFF_FFF5);
      chk("model ram1", m_ram[1], 64'd86);
      cycle(1, 0, 2'b01, 0, 0, "addr wrap");
      chk("lit x2 wrap", dut.u_rf.regs_q[2], 64'd3);
      cycle(1, 0, 2'b01, 1, 0, "x0 write");
      chk("lit x0", dut.u_rf.regs_q[0], 64'd0);
      chk("lit pc 32", program_counter, 64'd32);

      rand_cycles(200, "rand");

      // Asynchronous reset mid-cycle with writes still enabled.
      @(posedge clk);
      #3;
      load_en = 1'b1; store_en = 1'b1; operation_type = 1'b1;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("async");
      chk("async pc literal", program_counter, 64'd0);
      @(negedge clk);
      check_all("held");
      @(negedge clk);
      check_all("held2");
      reset = 1'b1;

      rand_cycles(150, "rand2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
